// File: rtl/conv_window_acc_ctrl_if.sv
// rtl/conv_window_acc_ctrl_if.sv - window/tree/result bus of conv_window_acc_ctrl
// acc_sat exists only when ACC_SAT_EN is defined.
interface conv_window_acc_ctrl_if #(
  parameter int ACC_W = 24,
  parameter int CH_W  = 8
);
  logic [CH_W-1:0]         cfg_num_ch;
  logic                    in_valid;
  logic                    in_ready;
  logic signed [8:0][15:0] in_data;
  logic signed [8:0][15:0] tree_a;
  logic signed [17:0]      tree_dout;
  logic                    out_valid;
  logic                    out_ready;
  logic signed [ACC_W-1:0] out_data;
  logic                    busy;
`ifdef ACC_SAT_EN
  logic                    acc_sat;
`endif

  modport slave (
    input  cfg_num_ch, in_valid, in_data, tree_dout, out_ready,
    output in_ready, tree_a, out_valid, out_data, busy
`ifdef ACC_SAT_EN
    , output acc_sat
`endif
  );

  modport master (
    output cfg_num_ch, in_valid, in_data, tree_dout, out_ready,
    input  in_ready, tree_a, out_valid, out_data, busy
`ifdef ACC_SAT_EN
    , input acc_sat
`endif
  );
endinterface

// File: rtl/conv_window_acc_ctrl.sv
// rtl/conv_window_acc_ctrl.sv - issues 3x3 windows into a 2-cycle adder tree and accumulates channels per pixel
// ACC_SAT_EN: saturating accumulation plus sticky acc_sat flag (default: wrap-around).
module conv_window_acc_ctrl #(
  parameter int ACC_W = 24,
  parameter int CH_W  = 8
) (
  input logic clk,
  input logic rst,
  conv_window_acc_ctrl_if.slave bus
);
  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ACCUM = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;
  localparam logic [1:0] S_HOLD  = 2'd3;

  logic [1:0]              state_q, state_d;
  logic [1:0]              v_q, v_d;
  logic [CH_W-1:0]         n_q, n_d, cnt_q, cnt_d;
  logic [CH_W-1:0]         cfg_n, cnt_inc;
  logic signed [ACC_W-1:0] acc_q, acc_d, dout_ext, add_res;
  logic                    accept, first_accept;

  assign bus.in_ready  = (state_q == S_IDLE) || (state_q == S_ACCUM);
  assign accept        = bus.in_valid && bus.in_ready;
  assign first_accept  = accept && (state_q == S_IDLE);
  assign bus.tree_a    = accept ? bus.in_data : '0;
  assign bus.out_valid = (state_q == S_HOLD);
  assign bus.out_data  = acc_q;
  assign bus.busy      = (state_q != S_IDLE);

  assign cfg_n    = (bus.cfg_num_ch == '0) ? CH_W'(1) : bus.cfg_num_ch;
  assign cnt_inc  = cnt_q + CH_W'(1);
  assign dout_ext = ACC_W'(bus.tree_dout);
  assign v_d      = {v_q[0], accept};

`ifdef ACC_SAT_EN
  logic signed [ACC_W:0] sum_wide;
  logic                  ovf;
  logic                  sat_q, sat_d;

  assign sum_wide = {acc_q[ACC_W-1], acc_q} + {dout_ext[ACC_W-1], dout_ext};
  assign ovf      = sum_wide[ACC_W] ^ sum_wide[ACC_W-1];
  // The extra sign bit tells which rail was crossed.
  assign add_res  = !ovf ? sum_wide[ACC_W-1:0]
                  : (sum_wide[ACC_W] ? {1'b1, {(ACC_W-1){1'b0}}}
                                     : {1'b0, {(ACC_W-1){1'b1}}});
  assign sat_d    = first_accept ? 1'b0 : ((v_q[1] && ovf) ? 1'b1 : sat_q);
  assign bus.acc_sat = sat_q;

  always_ff @(posedge clk) begin
    if (rst) sat_q <= 1'b0;
    else     sat_q <= sat_d;
  end
`else
  assign add_res = acc_q + dout_ext;
`endif

  always_comb begin
    acc_d = acc_q;
    if (first_accept)  acc_d = '0;
    else if (v_q[1])   acc_d = add_res;
  end

  always_comb begin
    state_d = state_q;
    n_d     = n_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_IDLE: if (accept) begin
        n_d     = cfg_n;
        cnt_d   = CH_W'(1);
        state_d = (cfg_n == CH_W'(1)) ? S_DRAIN : S_ACCUM;
      end
      S_ACCUM: if (accept) begin
        cnt_d = cnt_inc;
        if (cnt_inc == n_q) state_d = S_DRAIN;
      end
      // The last sum lands this cycle once nothing is left in the first stage.
      S_DRAIN: if (!v_q[0]) state_d = S_HOLD;
      S_HOLD:  if (bus.out_ready) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      v_q     <= '0;
      n_q     <= '0;
      cnt_q   <= '0;
      acc_q   <= '0;
    end else begin
      state_q <= state_d;
      v_q     <= v_d;
      n_q     <= n_d;
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
    end
  end
endmodule

// File: tb/tb_conv_window_acc_ctrl.sv
// tb/tb_conv_window_acc_ctrl.sv - scoreboard bench for conv_window_acc_ctrl with a 2-cycle 18-bit tree model
module tb_conv_window_acc_ctrl;
  localparam int ACC_W = 18;
  localparam int CH_W  = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   vectors = 0;
  int   miscompares = 0;
  int   last_acc = 0;

  typedef struct {
    logic signed [63:0] data;
    logic               sat;
    int                 rise;
  } exp_t;
  exp_t sb[$];

  conv_window_acc_ctrl_if #(.ACC_W(ACC_W), .CH_W(CH_W)) bus ();

  conv_window_acc_ctrl #(.ACC_W(ACC_W), .CH_W(CH_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Adder tree: 9 signed inputs, 18-bit wrapped sum, two register stages.
  function automatic logic signed [17:0] tree_sum(input logic signed [8:0][15:0] a);
    logic signed [19:0] s;
    s = '0;
    for (int i = 0; i < 9; i++) s = s + $signed(a[i]);
    return s[17:0];
  endfunction

  logic signed [17:0] p1 = '0, p2 = '0;
  always @(posedge clk) begin
    p1 <= tree_sum(bus.tree_a);
    p2 <= p1;
  end
  assign bus.tree_dout = p2;

  task automatic check(input string name, input logic signed [63:0] act, input logic signed [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic push_exp(input logic signed [63:0] data, input logic sat);
    exp_t e;
    e.data = data;
    e.sat  = sat;
    e.rise = last_acc + 3;
    sb.push_back(e);
  endtask

  task automatic send_window(input logic signed [15:0] e0, input logic signed [15:0] e1,
                             input logic signed [15:0] rest);
    logic accepted;
    accepted = 1'b0;
    for (int i = 0; i < 9; i++) bus.in_data[i] = (i == 0) ? e0 : ((i == 1) ? e1 : rest);
    bus.in_valid = 1'b1;
    for (int n = 0; n < 50 && !accepted; n++) begin
      @(negedge clk);
      if (bus.in_ready) begin
        accepted = 1'b1;
        last_acc = cyc;
        check("tree_a_pass", $signed(bus.tree_a[0]), e0);
      end
      @(posedge clk); #1;
    end
    bus.in_valid = 1'b0;
    bus.in_data  = '0;
    check("window_accepted", accepted, 1);
  endtask

  task automatic idle_cycle();
    @(posedge clk); #1;
  endtask

  task automatic wait_idle(input string name);
    logic done;
    done = 1'b0;
    for (int n = 0; n < 100 && !done; n++) begin
      @(negedge clk);
      if (!bus.busy && sb.size() == 0) done = 1'b1;
    end
    check(name, done, 1);
    @(posedge clk); #1;
  endtask

  // Monitor: latency on out_valid rise, data/sat on every handshake.
  logic ov_prev = 1'b0;
  always @(negedge clk) begin
    if (!rst) begin
      if (bus.out_valid && !ov_prev) begin
        if (sb.size() == 0) check("unexpected_out_valid", 1, 0);
        else                check("out_rise_cycle", cyc, sb[0].rise);
      end
      if (bus.out_valid && bus.out_ready) begin
        if (sb.size() == 0) check("unexpected_handshake", 1, 0);
        else begin
          exp_t e;
          e = sb.pop_front();
          check("out_data", bus.out_data, e.data);
`ifdef ACC_SAT_EN
          check("acc_sat", bus.acc_sat, e.sat);
`endif
        end
      end
    end
    ov_prev = bus.out_valid;
  end

  initial begin
    #300000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.cfg_num_ch = '0;
    bus.in_valid   = 1'b0;
    bus.in_data    = '0;
    bus.out_ready  = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_in_ready", bus.in_ready, 1);
    check("rst_out_valid", bus.out_valid, 0);
    check("rst_out_data", bus.out_data, 0);
    check("rst_busy", bus.busy, 0);
    check("rst_tree_a", bus.tree_a, 0);
    @(posedge clk); #1;
    rst = 1'b0;

    // Single channel, accept in cycle 10.
    bus.cfg_num_ch = 8'd1;
    while (cyc < 10) idle_cycle();
    send_window(1, 1, 1);
    check("single_accept_cycle", last_acc, 10);
    push_exp(9, 1'b0);
    do @(negedge clk); while (cyc < 14);
    check("single_busy_low_14", bus.busy, 0);
    @(posedge clk); #1;

    // Four channels back-to-back: 9*(1+2+3+4) = 90.
    bus.cfg_num_ch = 8'd4;
    for (int k = 1; k <= 4; k++) send_window(16'(k), 16'(k), 16'(k));
    push_exp(90, 1'b0);
    @(negedge clk);
    check("multi_in_ready_drop", bus.in_ready, 0);
    wait_idle("multi_done");

    // Gapped input, cfg change mid-pixel, backpressure: 3*9*(-2) = -54.
    bus.cfg_num_ch = 8'd3;
    bus.out_ready  = 1'b0;
    send_window(-2, -2, -2);
    bus.cfg_num_ch = 8'd7;
    idle_cycle();
    send_window(-2, -2, -2);
    idle_cycle();
    send_window(-2, -2, -2);
    push_exp(-54, 1'b0);
    for (int n = 0; n < 20 && !bus.out_valid; n++) @(negedge clk);
    for (int i = 0; i < 5; i++) begin
      check("bp_out_valid", bus.out_valid, 1);
      check("bp_out_data", bus.out_data, -54);
      check("bp_in_ready", bus.in_ready, 0);
      @(negedge clk);
    end
    @(posedge clk); #1;
    bus.out_ready = 1'b1;
    @(negedge clk);
    check("bp_in_ready_at_hs", bus.in_ready, 0);
    @(negedge clk);
    check("bp_in_ready_after_hs", bus.in_ready, 1);
    @(posedge clk); #1;

    // Zero config acts as one channel: 100 - 1 = 99.
    bus.cfg_num_ch = 8'd0;
    send_window(100, -1, 0);
    push_exp(99, 1'b0);
    wait_idle("zero_cfg_done");

    // Reset mid-pixel abandons it; fresh all-3 pixel gives 27.
    bus.cfg_num_ch = 8'd5;
    send_window(1, 1, 1);
    send_window(1, 1, 1);
    rst = 1'b1;
    idle_cycle();
    rst = 1'b0;
    @(negedge clk);
    check("midrst_busy", bus.busy, 0);
    check("midrst_out_valid", bus.out_valid, 0);
    @(posedge clk); #1;
    bus.cfg_num_ch = 8'd1;
    send_window(3, 3, 3);
    push_exp(27, 1'b0);
    wait_idle("midrst_done");

    // Overflow at ACC_W=18: each tree sum wraps to -114697.
    bus.cfg_num_ch = 8'd4;
    for (int k = 0; k < 4; k++) send_window(16383, 16383, 16383);
`ifdef ACC_SAT_EN
    push_exp(-131072, 1'b1);
`else
    push_exp(65500, 1'b0);
`endif
    wait_idle("overflow_done");

    repeat (5) idle_cycle();
    check("scoreboard_empty", sb.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
